// File: rtl/dct_pkg.sv
// Shared types and constants for the 2D DCT controller and its transpose buffer.
package dct_pkg;

    localparam int LANES = 32;
    localparam int DW    = 16;

    typedef enum logic [1:0] {
        SZ4  = 2'd0,
        SZ8  = 2'd1,
        SZ16 = 2'd2,
        SZ32 = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROW  = 2'd1,
        COL  = 2'd2
    } state_e;

    // Number of transform points for a size code: 4 << code.
    function automatic int size_of(input size_e code);
        return 4 << int'(code);
    endfunction

endpackage

// File: rtl/transpose_buf.sv
// Row-written, column-read register matrix between the row and column passes.
module transpose_buf
    import dct_pkg::*;
#(
    parameter int LANES = dct_pkg::LANES,
    parameter int DW    = dct_pkg::DW
) (
    input  logic                       clk,
    input  logic                       wr_en,
    input  logic [$clog2(LANES)-1:0]   wr_idx,
    input  logic [LANES*DW-1:0]        wr_row,
    input  logic [$clog2(LANES)-1:0]   rd_idx,
    input  size_e                      size,
    output logic [LANES*DW-1:0]        rd_col
);

    logic [DW-1:0] mem_q [LANES][LANES];

    // NOTE: storage carries no reset; every location read in a block is written by that block's row pass first.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < LANES; i++) begin
                mem_q[wr_idx][i] <= wr_row[i*DW +: DW];
            end
        end
    end

    // Rows at or above M may still hold data from a larger earlier block, so they are masked.
    always_comb begin
        rd_col = '0;
        for (int i = 0; i < LANES; i++) begin
            if (i < size_of(size)) begin
                rd_col[i*DW +: DW] = mem_q[i][rd_idx];
            end
        end
    end

endmodule

// File: rtl/dct2_2d_ctrl.sv
// Sequences a shared 1D DCT core through a row pass, a transpose, and a column pass.
module dct2_2d_ctrl
    import dct_pkg::*;
#(
    parameter int LANES = dct_pkg::LANES,
    parameter int DW    = dct_pkg::DW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            cfg_n,
    output logic                  busy,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*DW-1:0]   in_data,
    output logic [1:0]            core_n,
    output logic [LANES*DW-1:0]   core_x,
    input  logic [LANES*DW-1:0]   core_y,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*DW-1:0]   out_data,
    output logic                  done
);

    localparam int IW = $clog2(LANES);

    state_e                state_q, state_d;
    size_e                 size_q, size_d;
    logic [IW-1:0]         r_q, r_d;
    logic [IW-1:0]         c_q, c_d;
    logic                  out_valid_q, out_valid_d;
    logic [LANES*DW-1:0]   out_data_q, out_data_d;
    logic                  done_q, done_d;
    logic                  last_q, last_d;

    logic [IW-1:0]         last_idx;
    logic                  row_wr;
    logic [LANES*DW-1:0]   buf_col;

    assign last_idx = IW'(size_of(size_q) - 1);
    assign row_wr   = (state_q == ROW) && in_valid;

    transpose_buf #(
        .LANES (LANES),
        .DW    (DW)
    ) u_buf (
        .clk    (clk),
        .wr_en  (row_wr),
        .wr_idx (r_q),
        .wr_row (core_y),
        .rd_idx (c_q),
        .size   (size_q),
        .rd_col (buf_col)
    );

    // NOTE: every signal assigned here gets a default first, so no latch can be inferred.
    always_comb begin
        state_d     = state_q;
        size_d      = size_q;
        r_d         = r_q;
        c_d         = c_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        last_d      = last_q;
        done_d      = out_valid_q && out_ready && last_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            last_d      = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    size_d  = size_e'(cfg_n);
                    r_d     = '0;
                    state_d = ROW;
                end
            end
            ROW: begin
                if (in_valid) begin
                    r_d = r_q + IW'(1);
                    if (r_q == last_idx) begin
                        r_d     = '0;
                        c_d     = '0;
                        state_d = COL;
                    end
                end
            end
            COL: begin
                // A new column loads only when the register is empty or being drained this cycle.
                if (!out_valid_q || out_ready) begin
                    out_data_d  = core_y;
                    out_valid_d = 1'b1;
                    last_d      = (c_q == last_idx);
                    c_d         = c_q + IW'(1);
                    if (c_q == last_idx) begin
                        c_d     = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            size_q      <= SZ4;
            r_q         <= '0;
            c_q         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            size_q      <= size_d;
            r_q         <= r_d;
            c_q         <= c_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
            last_q      <= last_d;
        end
    end

    always_comb begin
        core_x = '0;
        case (state_q)
            ROW:     core_x = in_data;
            COL:     core_x = buf_col;
            default: core_x = '0;
        endcase
    end

    assign core_n    = size_q;
    assign in_ready  = (state_q == ROW);
    assign busy      = (state_q != IDLE) || out_valid_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign done      = done_q;

endmodule

// File: tb/tb_dct2_2d_ctrl.sv
// Self-checking bench: identity/negating core model plus a column scoreboard built from the input rows.
module tb_dct2_2d_ctrl;
    import dct_pkg::*;

    localparam int W = LANES * DW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [1:0]    cfg_n;
    logic          busy;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [1:0]    core_n;
    logic [W-1:0]  core_x;
    logic [W-1:0]  core_y;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_data;
    logic          done;

    dct2_2d_ctrl u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cfg_n     (cfg_n),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .core_n    (core_n),
        .core_x    (core_x),
        .core_y    (core_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Core model: identity, or per-lane two's-complement negation.
    logic neg_core = 1'b0;
    always_comb begin
        core_y = '0;
        for (int i = 0; i < LANES; i++) begin
            core_y[i*DW +: DW] = neg_core ? -core_x[i*DW +: DW] : core_x[i*DW +: DW];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Scoreboard of expected columns in output order, with a flag for each block's last column.
    logic [W-1:0] exp_q[$];
    bit           exp_last_q[$];
    logic [W-1:0] rows_a [LANES];

    bit           pend_done  = 1'b0;
    bit           prev_stall = 1'b0;
    bit           prev_valid = 1'b0;
    logic [W-1:0] prev_data  = '0;
    int           done_cnt   = 0;
    int           done_cyc   = 0;
    int           ov_rise_cyc = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            pend_done  = 1'b0;
            prev_stall = 1'b0;
            prev_valid = 1'b0;
        end else begin
            check("done", W'(done), W'(pend_done));
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (prev_stall) begin
                check("hold_valid", W'(out_valid), W'(1));
                check("hold_data", out_data, prev_data);
            end
            if (out_valid && !prev_valid) ov_rise_cyc = cyc;
            pend_done = 1'b0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_column: got %0h with no column outstanding", out_data);
                end else begin
                    check("column", out_data, exp_q.pop_front());
                    pend_done = exp_last_q.pop_front();
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_valid = out_valid;
            prev_data  = out_data;
        end
    end

    // out_ready modes: 0 = always high, 1 = repeating 1,0,0, 2 = random.
    int ready_mode = 0;
    int rpat       = 0;
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            1: begin
                out_ready = (rpat == 0);
                rpat      = (rpat + 1) % 3;
            end
            2:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b1;
        endcase
    end

    task automatic fill_rows(input int m, input bit rnd);
        for (int r = 0; r < LANES; r++) begin
            rows_a[r] = '0;
            if (r < m) begin
                for (int c = 0; c < m; c++) begin
                    rows_a[r][c*DW +: DW] = rnd ? DW'($urandom()) : DW'(16 * r + c);
                end
            end
        end
    endtask

    int blk_start_cyc;
    int last_row_cyc;

    // Starts a block, feeds M rows (optionally with gaps) and queues the transposed columns.
    // abort_after >= 0 pulses reset after that many rows instead of finishing the block.
    task automatic run_block(input int code, input bit stalls, input int abort_after);
        int m;
        int k;
        logic [W-1:0] col;
        m     = 4 << code;
        cfg_n = 2'(code);
        start = 1'b1;
        k     = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!in_ready && k < 300);
        start = 1'b0;
        cfg_n = 2'($urandom());
        if (!in_ready) begin
            fail_now("start_accept");
            return;
        end
        blk_start_cyc = cyc;
        for (int r = 0; r < m; r++) begin
            if (r == abort_after) begin
                in_valid = 1'b0;
                rst_n    = 1'b0;
                #1;
                check("abort_out_valid", W'(out_valid), W'(0));
                check("abort_busy", W'(busy), W'(0));
                check("abort_in_ready", W'(in_ready), W'(0));
                repeat (2) @(posedge clk);
                #1;
                rst_n = 1'b1;
                return;
            end
            if (stalls) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    in_data  = {16{$urandom()}};
                    @(posedge clk);
                    #1;
                end
            end
            in_valid = 1'b1;
            in_data  = rows_a[r];
            @(posedge clk);
            #1;
        end
        in_valid     = 1'b0;
        in_data      = {16{$urandom()}};
        last_row_cyc = cyc;
        for (int c = 0; c < m; c++) begin
            col = '0;
            for (int r = 0; r < m; r++) col[r*DW +: DW] = rows_a[r][c*DW +: DW];
            exp_q.push_back(col);
            exp_last_q.push_back(c == m - 1);
        end
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (busy && k < 1000) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (busy) fail_now("drain");
        repeat (2) @(posedge clk);
        #1;
    endtask

    logic [W-1:0] pin;
    int d0;

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        cfg_n    = 2'd0;
        in_valid = 1'b0;
        in_data  = '0;
        #3;
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_out_data", out_data, '0);
        check("rst_done", W'(done), W'(0));
        check("rst_busy", W'(busy), W'(0));
        check("rst_in_ready", W'(in_ready), W'(0));
        check("rst_core_n", W'(core_n), W'(0));
        check("rst_core_x", core_x, '0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // M=4 counting pattern, start-to-done span counted inclusively.
        fill_rows(4, 1'b0);
        d0 = done_cnt;
        run_block(0, 1'b0, -1);
        pin = exp_q[1];
        check("pin_m4_c1_l2", W'(pin[2*DW +: DW]), W'(33));
        check("pin_m4_c1_l5", W'(pin[5*DW +: DW]), W'(0));
        wait_drain();
        check("m4_done_count", W'(done_cnt - d0), W'(1));
        check("m4_start_to_done", W'(done_cyc - blk_start_cyc + 2), W'(11));

        // M=32 counting pattern; first column two cycles after the last row's cycle.
        fill_rows(32, 1'b0);
        run_block(3, 1'b0, -1);
        pin = exp_q[31];
        check("pin_m32_c31_l31", W'(pin[31*DW +: DW]), W'(527));
        wait_drain();
        check("m32_first_valid", W'(ov_rise_cyc - last_row_cyc + 1), W'(2));

        // M=8 with 1,0,0 backpressure; second start lands while the last column may be pending.
        ready_mode = 1;
        d0 = done_cnt;
        fill_rows(8, 1'b1);
        run_block(1, 1'b0, -1);
        fill_rows(8, 1'b1);
        run_block(1, 1'b1, -1);
        wait_drain();
        check("m8_done_count", W'(done_cnt - d0), W'(2));

        // Buffer full of M=32 data, then an M=4 block must show zero upper lanes.
        ready_mode = 0;
        fill_rows(32, 1'b1);
        run_block(3, 1'b0, -1);
        wait_drain();
        fill_rows(4, 1'b0);
        run_block(0, 1'b0, -1);
        wait_drain();

        // Reset after 2 of 8 rows, then a full M=8 block.
        fill_rows(8, 1'b1);
        run_block(1, 1'b0, 2);
        fill_rows(8, 1'b1);
        run_block(1, 1'b0, -1);
        wait_drain();

        // Negating core at M=16, with start pulsed during the column pass.
        neg_core   = 1'b1;
        ready_mode = 2;
        fill_rows(16, 1'b1);
        run_block(2, 1'b1, -1);
        start = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("col_start_ignored", W'(in_ready), W'(0));
        end
        start = 1'b0;
        wait_drain();
        neg_core = 1'b0;

        // Random sizes, stalls and backpressure.
        for (int b = 0; b < 4; b++) begin
            int code;
            code = $urandom_range(0, 3);
            fill_rows(4 << code, 1'b1);
            run_block(code, 1'b1, -1);
        end
        wait_drain();

        check("queue_empty", W'(exp_q.size()), W'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
